dmem_access_ctrl: RTL and testbench

Sequencer between the MEM stage and the data-memory bus. It turns the CU's per-instruction memory controls (read/write, byte/halfword/word mode, unsigned flag) into one or two word-aligned bus transactions using a req/gnt/rvalid handshake. It stalls the pipeline until the access completes, and returns the aligned, sign- or zero-extended load result to WB.

---
 rtl/dmem_ctrl_pkg.sv | 58 +++++
 rtl/dmem_load_align.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and helpers for the data-memory access sequencer.
// Supplies the common memory-mode defines when no other file has provided them,
// the sequencer state enum, byte-enable generation and write-lane shift helpers.
`ifndef MEMORY_MODE_WIDTH
`define MEMORY_MODE_WIDTH 2
`endif
`ifndef BYTE_MEMORY_MODE
`define BYTE_MEMORY_MODE 2'b00
`endif
`ifndef HALFWORD_MEMORY_MODE
`define HALFWORD_MEMORY_MODE 2'b01
`endif
`ifndef WORD_MEMORY_MODE
`define WORD_MEMORY_MODE 2'b10
`endif

package dmem_ctrl_pkg;

   localparam int DMEM_WORD_W = 32;
   localparam int DMEM_MODE_W = `MEMORY_MODE_WIDTH;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ0  = 3'd1,
      WAIT0 = 3'd2,
      REQ1  = 3'd3,
      WAIT1 = 3'd4,
      DONE  = 3'd5
   } dmem_state_e;

   // Seven-bit enable vector: [3:0] lanes of the first word, [6:4] spill into the next word.
   function automatic logic [6:0] byte_en_gen(input logic [DMEM_MODE_W-1:0] mode,
                                              input logic [1:0]             offset);
      logic [6:0] base_v;
      case (mode)
         `BYTE_MEMORY_MODE:     base_v = 7'b000_0001;
         `HALFWORD_MEMORY_MODE: base_v = 7'b000_0011;
         `WORD_MEMORY_MODE:     base_v = 7'b000_1111;
         default:               base_v = 7'b000_1111;
      endcase
      return base_v << offset;
   endfunction

   // Store data placed into the lanes of the first (lower) word.
   function automatic logic [DMEM_WORD_W-1:0] lane_shift_first(input logic [DMEM_WORD_W-1:0] wdata,
                                                               input logic [1:0]             offset);
      return wdata << {offset, 3'b000};
   endfunction

   // Store bytes that spill over into the second (upper) word.
   function automatic logic [DMEM_WORD_W-1:0] lane_shift_second(input logic [DMEM_WORD_W-1:0] wdata,
                                                                input logic [1:0]             offset);
      logic [5:0] amt_v;
      amt_v = 6'd32 - {1'b0, offset, 3'b000};
      return wdata >> amt_v;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load formatter. Picks the addressed bytes out of
// the two captured bus words and sign- or zero-extends them to a full register.
module dmem_load_align
   import dmem_ctrl_pkg::*;
(
   input  logic [2*DMEM_WORD_W-1:0] words,
   input  logic [1:0]               offset,
   input  logic [DMEM_MODE_W-1:0]   mode,
   input  logic                     mem_unsigned,
   output logic [DMEM_WORD_W-1:0]   rdata
);

   logic [2*DMEM_WORD_W-1:0] shifted_s;

   // Shift the addressed byte to lane 0, then truncate and extend by access size.
   always_comb begin
      shifted_s = words >> {offset, 3'b000};
      case (mode)
         `BYTE_MEMORY_MODE: begin
            if (mem_unsigned) begin
               rdata = {24'h00_0000, shifted_s[7:0]};
            end else begin
               rdata = {{24{shifted_s[7]}}, shifted_s[7:0]};
            end
         end
         `HALFWORD_MEMORY_MODE: begin
            if (mem_unsigned) begin
               rdata = {16'h0000, shifted_s[15:0]};
            end else begin
               rdata = {{16{shifted_s[15]}}, shifted_s[15:0]};
            end
         end
         default: rdata = shifted_s[31:0];
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage sequencer for the req/gnt/rvalid data bus.
// Turns one load/store into one or two word-aligned transactions, stalls the
// pipeline until the response arrives and hands the aligned load value to WB.
// Build option MISALIGNED_SPLIT_EN: when defined, word-crossing accesses are
// split into two transactions; otherwise they are rejected with misaligned_err.
module dmem_access_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mem_read,
   input  logic                         mem_write,
   input  logic [`MEMORY_MODE_WIDTH-1:0] mem_mode,
   input  logic                         mem_unsigned,
   input  logic [ADDR_WIDTH-1:0]        mem_addr,
   input  logic [DATA_WIDTH-1:0]        mem_wdata,
   output logic [DATA_WIDTH-1:0]        mem_rdata,
   output logic                         stall,
   output logic                         misaligned_err,
   output logic                         bus_req,
   output logic                         bus_we,
   output logic [ADDR_WIDTH-1:0]        bus_addr,
   output logic [3:0]                   bus_be,
   output logic [DATA_WIDTH-1:0]        bus_wdata,
   input  logic                         bus_gnt,
   input  logic                         bus_rvalid,
   input  logic [DATA_WIDTH-1:0]        bus_rdata
);

   dmem_state_e state_r, state_next_s;

   logic                         stall_prev_r;
   logic [ADDR_WIDTH-1:0]        addr_r;
   logic [DATA_WIDTH-1:0]        wdata_r;
   logic [`MEMORY_MODE_WIDTH-1:0] mode_r;
   logic                         unsigned_r;
   logic                         we_r;
   logic [DATA_WIDTH-1:0]        word0_r;
`ifdef MISALIGNED_SPLIT_EN
   logic [DATA_WIDTH-1:0]        word1_r;
`endif

   logic                         access_s, sample_s, accept_s, reject_s, cross_s;
   logic [ADDR_WIDTH-1:0]        src_addr_s, word_addr_s;
   logic [DATA_WIDTH-1:0]        src_wdata_s;
   logic [`MEMORY_MODE_WIDTH-1:0] src_mode_s;
   logic                         src_unsigned_s, src_we_s;
   logic [6:0]                   src_en_s;
   logic [DATA_WIDTH-1:0]        w0_s, w1_s, align_s;

   logic                         bus_req_next_s, bus_we_next_s;
   logic [ADDR_WIDTH-1:0]        bus_addr_next_s;
   logic [3:0]                   bus_be_next_s;
   logic [DATA_WIDTH-1:0]        bus_wdata_next_s, mem_rdata_next_s;

   // Access decode: in IDLE work from the live MEM-stage inputs, otherwise from the latched copy.
   always_comb begin
      access_s = mem_read | mem_write;
      sample_s = (state_r == IDLE) && !stall_prev_r && !rst;
      if (state_r == IDLE) begin
         src_addr_s     = mem_addr;
         src_wdata_s    = mem_wdata;
         src_mode_s     = mem_mode;
         src_unsigned_s = mem_unsigned;
         src_we_s       = mem_write;
      end else begin
         src_addr_s     = addr_r;
         src_wdata_s    = wdata_r;
         src_mode_s     = mode_r;
         src_unsigned_s = unsigned_r;
         src_we_s       = we_r;
      end
      src_en_s    = byte_en_gen(src_mode_s, src_addr_s[1:0]);
      cross_s     = |src_en_s[6:4];
      word_addr_s = {src_addr_s[ADDR_WIDTH-1:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
      reject_s = 1'b0;
`else
      reject_s = sample_s & access_s & cross_s;
`endif
      accept_s       = sample_s & access_s & ~reject_s;
      stall          = accept_s | (state_r inside {REQ0, WAIT0, REQ1, WAIT1});
      misaligned_err = reject_s;
   end

   // Next-state logic for the transaction sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_next_s = REQ0;
            else          state_next_s = IDLE;
         end
         REQ0: begin
            if (bus_gnt) state_next_s = WAIT0;
            else         state_next_s = REQ0;
         end
         WAIT0: begin
            if (bus_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
               if (cross_s) state_next_s = REQ1;
               else         state_next_s = DONE;
`else
               state_next_s = DONE;
`endif
            end else begin
               state_next_s = WAIT0;
            end
         end
`ifdef MISALIGNED_SPLIT_EN
         REQ1: begin
            if (bus_gnt) state_next_s = WAIT1;
            else         state_next_s = REQ1;
         end
         WAIT1: begin
            if (bus_rvalid) state_next_s = DONE;
            else            state_next_s = WAIT1;
         end
`endif
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Response words: the word arriving this cycle bypasses its register so DONE can be registered.
   always_comb begin
      if (state_r == WAIT0) w0_s = bus_rdata;
      else                  w0_s = word0_r;
`ifdef MISALIGNED_SPLIT_EN
      if (state_r == WAIT1) w1_s = bus_rdata;
      else                  w1_s = word1_r;
`else
      w1_s = {DATA_WIDTH{1'b0}};
`endif
   end

   dmem_load_align u_load_align (
      .words        ({w1_s, w0_s}),
      .offset       (src_addr_s[1:0]),
      .mode         (src_mode_s),
      .mem_unsigned (src_unsigned_s),
      .rdata        (align_s)
   );

   // Bus and result values for the state being entered; registered below so outputs are glitch-free.
   always_comb begin
      bus_req_next_s   = 1'b0;
      bus_we_next_s    = 1'b0;
      bus_addr_next_s  = {ADDR_WIDTH{1'b0}};
      bus_be_next_s    = 4'b0000;
      bus_wdata_next_s = {DATA_WIDTH{1'b0}};
      mem_rdata_next_s = {DATA_WIDTH{1'b0}};
      case (state_next_s)
         REQ0: begin
            bus_req_next_s   = 1'b1;
            bus_we_next_s    = src_we_s;
            bus_addr_next_s  = word_addr_s;
            bus_be_next_s    = src_en_s[3:0];
            bus_wdata_next_s = lane_shift_first(src_wdata_s, src_addr_s[1:0]);
         end
`ifdef MISALIGNED_SPLIT_EN
         REQ1: begin
            bus_req_next_s   = 1'b1;
            bus_we_next_s    = src_we_s;
            bus_addr_next_s  = word_addr_s + ADDR_WIDTH'(4);
            bus_be_next_s    = {1'b0, src_en_s[6:4]};
            bus_wdata_next_s = lane_shift_second(src_wdata_s, src_addr_s[1:0]);
         end
`endif
         DONE: begin
            if (src_we_s) mem_rdata_next_s = {DATA_WIDTH{1'b0}};
            else          mem_rdata_next_s = align_s;
         end
         default: begin
            bus_req_next_s = 1'b0;
         end
      endcase
   end

   // State register, previous-cycle stall and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         stall_prev_r   <= 1'b0;
         bus_req        <= 1'b0;
         bus_we         <= 1'b0;
         bus_addr       <= {ADDR_WIDTH{1'b0}};
         bus_be         <= 4'b0000;
         bus_wdata      <= {DATA_WIDTH{1'b0}};
         mem_rdata      <= {DATA_WIDTH{1'b0}};
      end else begin
         state_r        <= state_next_s;
         stall_prev_r   <= stall;
         bus_req        <= bus_req_next_s;
         bus_we         <= bus_we_next_s;
         bus_addr       <= bus_addr_next_s;
         bus_be         <= bus_be_next_s;
         bus_wdata      <= bus_wdata_next_s;
         mem_rdata      <= mem_rdata_next_s;
      end
   end

   // Latch the MEM-stage request and capture response words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_r     <= {ADDR_WIDTH{1'b0}};
         wdata_r    <= {DATA_WIDTH{1'b0}};
         mode_r     <= {`MEMORY_MODE_WIDTH{1'b0}};
         unsigned_r <= 1'b0;
         we_r       <= 1'b0;
         word0_r    <= {DATA_WIDTH{1'b0}};
`ifdef MISALIGNED_SPLIT_EN
         word1_r    <= {DATA_WIDTH{1'b0}};
`endif
      end else begin
         if (accept_s) begin
            addr_r     <= mem_addr;
            wdata_r    <= mem_wdata;
            mode_r     <= mem_mode;
            unsigned_r <= mem_unsigned;
            we_r       <= mem_write;
         end
         if (state_r == WAIT0 && bus_rvalid) begin
            word0_r <= bus_rdata;
         end
`ifdef MISALIGNED_SPLIT_EN
         if (state_r == WAIT1 && bus_rvalid) begin
            word1_r <= bus_rdata;
         end
`endif
      end
   end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: randomized self-checking bench for dmem_access_ctrl.
// A byte-level memory model predicts bus transactions, stall length and load results.
module tb_dmem_access_ctrl;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
   logic [`MEMORY_MODE_WIDTH-1:0] mem_mode = `WORD_MEMORY_MODE;
   logic [31:0]                   mem_addr = 32'h0, mem_wdata = 32'h0;
   logic [31:0]                   mem_rdata, bus_addr, bus_wdata;
   logic [31:0]                   bus_rdata = 32'h0;
   logic                          stall, misaligned_err, bus_req, bus_we;
   logic [3:0]                    bus_be;
   logic                          bus_gnt = 1'b0, bus_rvalid = 1'b0;

   int err_cnt = 0;
   int chk_cnt = 0;

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } txn_t;

   logic [7:0] mem_q [int unsigned];

   dmem_access_ctrl dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode),
      .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall(stall), .misaligned_err(misaligned_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (mem_q.exists(a)) return mem_q[a];
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) mem_q[a + 32'(i)] = w[i*8 +: 8];
   endtask

   // One MEM-stage access with a scripted bus responder and full result checking.
   task automatic run_access(input logic rd, input logic wr, input logic [`MEMORY_MODE_WIDTH-1:0] mode,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_wait, input int rv_wait, input string tag);
      int          size, ntx, exp_stall, stall_cnt, cyc, gw, rw, idx;
      bit          reject, done, saw_err, granted, pend_valid;
      logic [31:0] exp_rdata, got_rdata, a, resp_addr, v, mask;
      txn_t        exp_q[$], got_q[$];
      txn_t        t, pend;

      size = (mode == `BYTE_MEMORY_MODE) ? 1 : (mode == `HALFWORD_MEMORY_MODE) ? 2 : 4;
      reject = (int'(addr[1:0]) + size > 4) && !SPLIT;
      // Expected bus transactions, grouped by word in ascending order.
      for (int i = 0; i < size; i++) begin
         a = addr + 32'(i);
         idx = -1;
         for (int k = 0; k < exp_q.size(); k++) if (exp_q[k].addr == {a[31:2], 2'b00}) idx = k;
         if (idx < 0) begin
            t.addr = {a[31:2], 2'b00}; t.be = 4'b0000; t.wdata = 32'h0; t.we = wr;
            exp_q.push_back(t);
            idx = exp_q.size() - 1;
         end
         t = exp_q[idx];
         t.be[a[1:0]] = 1'b1;
         t.wdata[int'(a[1:0])*8 +: 8] = wdata[i*8 +: 8];
         exp_q[idx] = t;
      end
      if (reject) exp_q.delete();
      ntx = exp_q.size();
      exp_stall = reject ? 0 : (2*ntx + 1 + ntx*gnt_wait + ntx*rv_wait);
      v = 32'h0;
      for (int i = 0; i < size; i++) v[i*8 +: 8] = mem_byte(addr + 32'(i));
      if (!uns && size < 4 && v[size*8-1]) for (int j = size*8; j < 32; j++) v[j] = 1'b1;
      exp_rdata = (wr || reject) ? 32'h0 : v;

      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; mem_mode = mode; mem_unsigned = uns;
      mem_addr = addr; mem_wdata = wdata;
      done = 0; saw_err = 0; granted = 0; pend_valid = 0; stall_cnt = 0; cyc = 0;
      gw = 0; rw = 0; got_rdata = 32'h0; resp_addr = 32'h0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (stall) stall_cnt++;
         if (misaligned_err) saw_err = 1;
         if (!stall) begin
            done = 1;
            got_rdata = mem_rdata;
         end
         bus_rvalid = 1'b0;
         if (granted) begin
            if (rw > 0) rw--;
            else begin
               bus_rvalid = 1'b1;
               bus_rdata = mem_word(resp_addr);
               granted = 0;
            end
         end
         if (bus_req) begin
            if (!pend_valid) begin
               pend.addr = bus_addr; pend.be = bus_be; pend.wdata = bus_wdata; pend.we = bus_we;
               got_q.push_back(pend);
               pend_valid = 1;
               gw = gnt_wait;
            end else begin
               check_val({tag, " hold addr"}, bus_addr, pend.addr);
               check_val({tag, " hold be"}, 32'(bus_be), 32'(pend.be));
               check_val({tag, " hold wdata"}, bus_wdata, pend.wdata);
            end
            if (gw > 0) begin
               gw--;
               bus_gnt = 1'b0;
            end else begin
               bus_gnt = 1'b1;
               granted = 1;
               rw = rv_wait;
               resp_addr = bus_addr;
               pend_valid = 0;
            end
         end else begin
            bus_gnt = 1'b0;
         end
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      mem_read = 1'b0; mem_write = 1'b0;

      check_val({tag, " completed"}, 32'(done), 32'd1);
      check_val({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
      check_val({tag, " misaligned_err"}, 32'(saw_err), 32'(reject));
      check_val({tag, " mem_rdata"}, got_rdata, exp_rdata);
      check_val({tag, " txn count"}, 32'(got_q.size()), 32'(ntx));
      for (int k = 0; k < ntx && k < got_q.size(); k++) begin
         for (int b = 0; b < 4; b++) mask[b*8 +: 8] = {8{exp_q[k].be[b]}};
         check_val({tag, " bus_addr"}, got_q[k].addr, exp_q[k].addr);
         check_val({tag, " bus_be"}, 32'(got_q[k].be), 32'(exp_q[k].be));
         check_val({tag, " bus_we"}, 32'(got_q[k].we), 32'(exp_q[k].we));
         check_val({tag, " bus_wdata"}, got_q[k].wdata & mask, exp_q[k].wdata);
      end
      if (wr && !reject) for (int i = 0; i < size; i++) mem_q[addr + 32'(i)] = wdata[i*8 +: 8];
   endtask

   initial begin
      logic [`MEMORY_MODE_WIDTH-1:0] rmode;
      logic [31:0] raddr;
      logic        rrd, rwr;
      int          sel;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_val("rst bus_req", 32'(bus_req), 32'd0);
      check_val("rst bus_we", 32'(bus_we), 32'd0);
      check_val("rst bus_addr", bus_addr, 32'h0);
      check_val("rst bus_be", 32'(bus_be), 32'd0);
      check_val("rst bus_wdata", bus_wdata, 32'h0);
      check_val("rst mem_rdata", mem_rdata, 32'h0);
      check_val("rst misaligned_err", 32'(misaligned_err), 32'd0);
      check_val("rst stall", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      set_word(32'h100, 32'hDEADBEEF);
      run_access(1'b1, 1'b0, `WORD_MEMORY_MODE, 1'b0, 32'h100, 32'h0, 0, 0, "LW 0x100");
      set_word(32'h100, 32'h80FFFFFF);
      run_access(1'b1, 1'b0, `BYTE_MEMORY_MODE, 1'b0, 32'h103, 32'h0, 0, 0, "LB 0x103");
      run_access(1'b1, 1'b0, `BYTE_MEMORY_MODE, 1'b1, 32'h103, 32'h0, 0, 0, "LBU 0x103");
      run_access(1'b0, 1'b1, `HALFWORD_MEMORY_MODE, 1'b0, 32'h102, 32'h0000ABCD, 0, 0, "SH 0x102");
      set_word(32'h200, 32'h44332211);
      set_word(32'h204, 32'h88776655);
      run_access(1'b1, 1'b0, `WORD_MEMORY_MODE, 1'b0, 32'h201, 32'h0, 0, 0, "LW 0x201");
      run_access(1'b1, 1'b0, `WORD_MEMORY_MODE, 1'b0, 32'h100, 32'h0, 4, 0, "LW gnt wait");
      run_access(1'b1, 1'b1, `HALFWORD_MEMORY_MODE, 1'b0, 32'h123, 32'h1234CAFE, 1, 2, "RW half x");

      // Reset while waiting for the read response.
      @(posedge clk); #1;
      mem_read = 1'b1; mem_mode = `WORD_MEMORY_MODE; mem_addr = 32'h300;
      @(negedge clk);
      @(negedge clk);
      check_val("rst-mid req seen", 32'(bus_req), 32'd1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      rst = 1'b1;
      #1;
      check_val("rst-mid bus_req", 32'(bus_req), 32'd0);
      check_val("rst-mid stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'h13572468;
      @(negedge clk);
      bus_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_val("late rvalid stall", 32'(stall), 32'd0);
         check_val("late rvalid mem_rdata", mem_rdata, 32'h0);
         check_val("late rvalid bus_req", 32'(bus_req), 32'd0);
         @(negedge clk);
      end

      // Randomized accesses against the byte-level model.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 2);
         rmode = (sel == 0) ? `BYTE_MEMORY_MODE : (sel == 1) ? `HALFWORD_MEMORY_MODE : `WORD_MEMORY_MODE;
         raddr = 32'h400 + 32'($urandom_range(0, 255));
         sel = $urandom_range(0, 4);
         rrd = (sel != 1);
         rwr = (sel == 1) || (sel == 4);
         run_access(rrd, rwr, rmode, 1'($urandom_range(0, 1)), raddr, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2), "random");
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
